// File: rtl/rx_frame_fifo_writer.sv
// rx_frame_fifo_writer: tags a non-stallable MAC RX byte stream with frame
// delimiters and pushes it into the async frame FIFO through a one-entry
// holding register. Frames that overflow, exceed MAX_LEN or break protocol
// are closed with an abort word, and the rest of the frame is discarded.
module rx_frame_fifo_writer #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_sof,
    input  logic                  rx_eof,
    input  logic                  rx_err,
    output logic                  fifo_w_en,
    output logic [DATA_WIDTH-1:0] fifo_w_data,
    input  logic                  fifo_w_full,
    output logic [15:0]           good_cnt,
    output logic [15:0]           abort_cnt,
    output logic                  busy
);

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PASS  = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    localparam logic [10:0] ABORT_WORD = 11'h600;

    logic [1:0]            state_q,      state_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_word_q,  hold_word_d;
    logic [LEN_W-1:0]      len_q,        len_d;
    logic                  eof_seen_q,   eof_seen_d;
    logic [CNT_W-1:0]      good_q,       good_d;
    logic [CNT_W-1:0]      abort_q,      abort_d;
    logic                  busy_q,       busy_d;

    logic slot_free;
    logic eof_now;
    logic good_inc;
    logic abort_inc;

    // Zero-extend an 11-bit tagged word {err, eof, sof, data} to the FIFO width.
    function automatic logic [DATA_WIDTH-1:0] mk_word(input logic [10:0] w);
        return DATA_WIDTH'(w);
    endfunction

    // State and holding-register flops.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q      <= S_IDLE;
            hold_valid_q <= 1'b0;
            hold_word_q  <= '0;
            len_q        <= '0;
            eof_seen_q   <= 1'b0;
            good_q       <= '0;
            abort_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_word_q  <= hold_word_d;
            len_q        <= len_d;
            eof_seen_q   <= eof_seen_d;
            good_q       <= good_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, holding-register load and frame counters.
    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q && fifo_w_full;
        hold_word_d  = hold_word_q;
        len_d        = len_q;
        eof_seen_d   = eof_seen_q;
        good_inc     = 1'b0;
        abort_inc    = 1'b0;
        slot_free    = !hold_valid_q || !fifo_w_full;
        eof_now      = eof_seen_q || (rx_valid && rx_eof);

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_sof) begin
                    if (slot_free) begin
                        hold_valid_d = 1'b1;
                        hold_word_d  = mk_word({rx_err && rx_eof, rx_eof, 1'b1, rx_data});
                        len_d        = LEN_W'(1);
                        if (rx_eof) begin
                            good_inc  = !rx_err;
                            abort_inc = rx_err;
                        end else begin
                            state_d = S_PASS;
                        end
                    end else begin
                        // No room for the first byte: drop the whole frame.
                        abort_inc = 1'b1;
                        if (!rx_eof) state_d = S_DROP;
                    end
                end
            end
            S_PASS: begin
                if (rx_valid) begin
                    if (rx_sof || (len_q == LEN_W'(MAX_LEN)) ||
                        (rx_err && !rx_eof) || !slot_free) begin
                        state_d    = S_ABORT;
                        abort_inc  = 1'b1;
                        eof_seen_d = rx_eof;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_word_d  = mk_word({rx_err && rx_eof, rx_eof, 1'b0, rx_data});
                        len_d        = len_q + LEN_W'(1);
                        if (rx_eof) begin
                            state_d   = S_IDLE;
                            good_inc  = !rx_err;
                            abort_inc = rx_err;
                        end
                    end
                end
            end
            S_ABORT: begin
                eof_seen_d = eof_now;
                if (slot_free) begin
                    hold_valid_d = 1'b1;
                    hold_word_d  = mk_word(ABORT_WORD);
                    eof_seen_d   = 1'b0;
                    state_d      = eof_now ? S_IDLE : S_DROP;
                end
            end
            S_DROP: begin
                if (rx_valid && rx_eof) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        good_d  = (good_inc && (good_q != '1))   ? good_q  + CNT_W'(1) : good_q;
        abort_d = (abort_inc && (abort_q != '1)) ? abort_q + CNT_W'(1) : abort_q;
        busy_d  = (state_d != S_IDLE) || hold_valid_d;
    end

    assign fifo_w_en   = hold_valid_q;
    assign fifo_w_data = hold_word_q;
    assign good_cnt    = good_q;
    assign abort_cnt   = abort_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rx_frame_fifo_writer.sv
// Directed bench for rx_frame_fifo_writer with a scoreboard of expected FIFO words.
module tb_rx_frame_fifo_writer;

    localparam int unsigned DW = 11;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          rx_valid, rx_sof, rx_eof, rx_err;
    logic [7:0]    rx_data;
    logic          fifo_w_en;
    logic [DW-1:0] fifo_w_data;
    logic          fifo_w_full;
    logic [15:0]   good_cnt, abort_cnt;
    logic          busy;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];

    rx_frame_fifo_writer #(.DATA_WIDTH(DW), .MAX_LEN(8), .LEN_W(16)) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_err      (rx_err),
        .fifo_w_en   (fifo_w_en),
        .fifo_w_data (fifo_w_data),
        .fifo_w_full (fifo_w_full),
        .good_cnt    (good_cnt),
        .abort_cnt   (abort_cnt),
        .busy        (busy)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one clock, returning 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] d, input logic s, input logic e, input logic er);
        rx_valid = 1'b1; rx_data = d; rx_sof = s; rx_eof = e; rx_err = er;
        @(posedge wclk); #1;
        rx_valid = 1'b0; rx_data = 8'h00; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    // Every accepted FIFO write is checked against the head of the scoreboard.
    always @(negedge wclk) begin
        if (wrst_n && fifo_w_en && !fifo_w_full) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(fifo_w_data), 32'hFFFF_FFFF);
            end else begin
                chk("fifo_word", 32'(fifo_w_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        wrst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_sof = 1'b0;
        rx_eof = 1'b0; rx_err = 1'b0; fifo_w_full = 1'b0;
        #23;
        chk("rst_w_en",  32'(fifo_w_en),   32'h0);
        chk("rst_data",  32'(fifo_w_data), 32'h0);
        chk("rst_good",  32'(good_cnt),    32'h0);
        chk("rst_abort", 32'(abort_cnt),   32'h0);
        chk("rst_busy",  32'(busy),        32'h0);
        wrst_n = 1'b1;
        idle(2);

        // Clean 4-byte frame.
        exp_q.push_back(11'h1A0); exp_q.push_back(11'h0A1);
        exp_q.push_back(11'h0A2); exp_q.push_back(11'h2A3);
        send(8'hA0, 1'b1, 1'b0, 1'b0);
        chk("a0_latency_en",   32'(fifo_w_en),   32'h1);
        chk("a0_latency_data", 32'(fifo_w_data), 32'h1A0);
        send(8'hA1, 1'b0, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0, 1'b0);
        send(8'hA3, 1'b0, 1'b1, 1'b0);
        chk("a3_busy_high", 32'(busy), 32'h1);
        chk("a_good", 32'(good_cnt), 32'h1);
        idle(1);
        chk("a_busy_low", 32'(busy), 32'h0);
        idle(2);

        // Overflow: full high for bytes 3 and 4 of an 8-byte frame.
        exp_q.push_back(11'h1E0); exp_q.push_back(11'h0E1);
        exp_q.push_back(11'h0E2); exp_q.push_back(11'h600);
        for (int i = 0; i < 8; i++) begin
            fifo_w_full = (i == 3) || (i == 4);
            send(8'(224 + i), i == 0, i == 7, 1'b0);
        end
        fifo_w_full = 1'b0;
        idle(3);
        chk("ovf_abort", 32'(abort_cnt), 32'h1);
        exp_q.push_back(11'h1F0); exp_q.push_back(11'h2F1);
        send(8'hF0, 1'b1, 1'b0, 1'b0);
        send(8'hF1, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("ovf_next_good", 32'(good_cnt), 32'h2);

        // 10-byte frame against MAX_LEN = 8.
        exp_q.push_back(11'h130);
        for (int i = 1; i < 8; i++) exp_q.push_back(11'(48 + i));
        exp_q.push_back(11'h600);
        for (int i = 0; i < 10; i++) send(8'(48 + i), i == 0, i == 9, 1'b0);
        idle(4);
        chk("maxlen_abort", 32'(abort_cnt), 32'h2);
        chk("maxlen_good",  32'(good_cnt),  32'h2);
        chk("maxlen_drain", 32'(exp_q.size()), 32'h0);

        // Error on the eof byte, then error on a middle byte.
        exp_q.push_back(11'h1B0); exp_q.push_back(11'h6B1);
        send(8'hB0, 1'b1, 1'b0, 1'b0);
        send(8'hB1, 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("err_eof_abort", 32'(abort_cnt), 32'h3);
        exp_q.push_back(11'h150); exp_q.push_back(11'h051); exp_q.push_back(11'h600);
        send(8'h50, 1'b1, 1'b0, 1'b0);
        send(8'h51, 1'b0, 1'b0, 1'b0);
        send(8'h52, 1'b0, 1'b0, 1'b1);
        send(8'h53, 1'b0, 1'b0, 1'b0);
        send(8'h54, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("err_mid_abort", 32'(abort_cnt), 32'h4);
        chk("err_mid_idle_busy", 32'(busy), 32'h0);

        // Stray byte, single-byte frame, sof in the middle of a frame.
        send(8'h77, 1'b0, 1'b0, 1'b0);
        idle(2);
        exp_q.push_back(11'h3C5);
        send(8'hC5, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("single_good", 32'(good_cnt), 32'h3);
        exp_q.push_back(11'h160); exp_q.push_back(11'h061); exp_q.push_back(11'h600);
        send(8'h60, 1'b1, 1'b0, 1'b0);
        send(8'h61, 1'b0, 1'b0, 1'b0);
        send(8'h70, 1'b1, 1'b0, 1'b0);
        send(8'h71, 1'b0, 1'b0, 1'b0);
        send(8'h72, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("sof_mid_abort", 32'(abort_cnt), 32'h5);
        chk("sof_mid_good",  32'(good_cnt),  32'h3);
        chk("sof_mid_drain", 32'(exp_q.size()), 32'h0);

        // Reset mid-frame with the hold register full.
        fifo_w_full = 1'b1;
        send(8'h90, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_en", 32'(fifo_w_en), 32'h1);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_en",    32'(fifo_w_en), 32'h0);
        chk("mid_rst_good",  32'(good_cnt),  32'h0);
        chk("mid_rst_abort", 32'(abort_cnt), 32'h0);
        chk("mid_rst_busy",  32'(busy),      32'h0);
        wrst_n = 1'b1;
        fifo_w_full = 1'b0;
        idle(1);
        exp_q.push_back(11'h1D0); exp_q.push_back(11'h2D1);
        send(8'hD0, 1'b1, 1'b0, 1'b0);
        send(8'hD1, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("post_rst_good", 32'(good_cnt), 32'h1);
        chk("final_drain", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
